data_mem_responder: RTL
=======================

# data_mem_responder

Word-organised data memory that answers the core's `d_mem_*` load/store bus.

- Latches one request per transaction and inserts a configurable number of wait states.
- Performs the byte-lane read or write, then pulses `d_mem_rdy` for one cycle.
- Sits between the core and on-chip data RAM; it is the simulation and FPGA target for the LSU.
- A write-protected word window (ROM/vector area) acknowledges writes but discards them and flags a fault.

## Interface

- `AW`, 10: word-address bits used. The array holds 2^AW 16-bit words. Legal range 1..15.
- `RD_WAIT`, 1: wait cycles inserted before a read completes. Range 0..15.
- `WR_WAIT`, 0: wait cycles inserted before a write completes. Range 0..15.
- `WP_LO`, 16'hFFF0: first protected word index (inclusive).
- `WP_HI`, 16'hFFFF: last protected word index (inclusive). Protection is disabled when `WP_LO > WP_HI`.

- `clk`  in  1  clock. All state changes on its rising edge.
- `a_rst`  in  1  reset; synchronous and active-low.
- `d_mem_assert`  in  1  request valid. Held high, with stable fields, until `d_mem_rdy` is sampled.
- `d_mem_cmd`  in  1  direction: 1 = write, 0 = read.
- `d_mem_addr`  in  16  byte address. Word index = `addr[AW:1]`; `addr[0]` and `addr[15:AW+1]` are ignored, so upper addresses alias.
- `d_mem_data_out`  in  16  write data. Bits [7:0] are lane 0; bits [15:8] are lane 1.
- `d_mem_be0`  in  1  lane 0 enable.
- `d_mem_be1`  in  1  lane 1 enable.
- `d_mem_rdy`  out  1  one-cycle completion pulse.
- `d_mem_data_in`  out  16  read data register.
- `wp_fault`  out  1  one-cycle pulse, coincident with `d_mem_rdy`, on a write to the protected window.

## Operation

- FSM states are IDLE, WAIT and ACK.
- **IDLE**
  - If `d_mem_assert` is high: latch cmd, word index, data, be0 and be1.
  - Load the counter with `cmd ? WR_WAIT : RD_WAIT`.
  - Go to WAIT if the count is nonzero, otherwise go to ACK.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 1, the next state is ACK.
  - Input changes during WAIT are ignored; only latched values are used.
- **Entering ACK (the transition edge)** performs the access:
  - Read: `d_mem_data_in <= mem[idx]`, full word regardless of byte enables.
  - Write: for each enabled lane, write `mem[idx]` lane ← data lane, unless the word index falls in [`WP_LO`, `WP_HI`] (compared on the zero-extended index). A protected write changes nothing and sets `wp_fault` for the ACK cycle.
  - Write with be0 = be1 = 0: no array change, acknowledged normally.
- **ACK**
  - `d_mem_rdy` = 1.
  - `d_mem_assert` is ignored in this cycle, because the core still presents the completing request.
  - Always go to IDLE.
- `d_mem_data_in` changes only on read completion and holds its value across writes and idle cycles.
- Array contents are not reset and are undefined until written.

## Timing

- Reset (`a_rst` low at an edge) forces:
  - state IDLE and counter 0
  - `d_mem_rdy` = 0, `wp_fault` = 0, `d_mem_data_in` = 16'h0000
- Reset mid-transaction (WAIT or ACK) aborts the access. A write not yet past its ACK-entry edge never commits.
- Latency, counting from the edge that samples `d_mem_assert` in IDLE to the `d_mem_rdy` cycle:
  - rdy is high in cycle N + 1 + wait, where N is the request cycle.
  - wait = 0: rdy is in the cycle after the request.
- Throughput:
  - At most one transaction per 2 + wait cycles.
  - A back-to-back request held high after ACK is sampled in the following IDLE cycle.
- `d_mem_rdy` and `wp_fault` are registered outputs, with no combinational path from any input.
- `d_mem_data_in` is valid from the start of the ACK cycle of a read until the next read ACK.
- Read after write to the same word returns the written data: the write commits before the read's ACK-entry edge.

## Test plan

1. **Reset.** Hold `a_rst` low for 2 cycles mid-WAIT of a write to word 5 with `d_mem_data_out` = 16'hDEAD.
   - During reset: `d_mem_rdy` = 0 and `d_mem_data_in` = 0.
   - A later read of word 5 with RD_WAIT = 1 does not return DEAD.
2. **Zero-wait write and read.** WR_WAIT = 0. Write 16'h1234 to addr 16'h0010 with both lanes enabled.
   - rdy is in the cycle after the request.
   - A read of 16'h0011 (aliases word 8) with RD_WAIT = 1 gives rdy 2 cycles after the request and data 16'h1234.
3. **Byte lanes.** Write 16'hAABB to word 3 with be1 only, over initial 16'h1234 → readback 16'hAA34. Repeat with be0 only → readback 16'hAABB's low lane merged, i.e. 16'hAABB.
4. **Write protect.** Write 16'h5555 to word 16'h3F8 with WP_LO = 16'h3F0, WP_HI = 16'h3FF.
   - `wp_fault` and `d_mem_rdy` are high together for one cycle.
   - Readback equals the prior contents.
5. **Back-to-back and stability.** Hold `d_mem_assert` continuously across 4 reads with RD_WAIT = 2, changing `d_mem_addr` during WAIT.
   - rdy every 4th cycle.
   - Each read returns the data at the address latched in IDLE.
   - `d_mem_data_in` is unchanged across an intervening write.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised 16-bit data RAM answering the core's
// d_mem_* load/store bus. Each request is latched in IDLE, optionally delayed
// by a fixed number of wait states, and completed with a one-cycle d_mem_rdy
// pulse. Writes into the protected word window are acknowledged but dropped,
// and raise wp_fault alongside d_mem_rdy.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for d_mem_assert; latches the request when it arrives
// S_WAIT | counting down wait states using only the latched request
// S_ACK  | d_mem_rdy high for one cycle; request input ignored
//
// The array access happens on the edge that enters S_ACK. When there are no
// wait states that edge is the IDLE sampling edge, so the access fields come
// straight from the bus; otherwise they come from the latched copy.

module data_mem_responder #(
    parameter int          AW      = 10,
    parameter int          RD_WAIT = 1,
    parameter int          WR_WAIT = 0,
    parameter logic [15:0] WP_LO   = 16'hFFF0,
    parameter logic [15:0] WP_HI   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        d_mem_assert,
    input  logic        d_mem_cmd,
    input  logic [15:0] d_mem_addr,
    input  logic [15:0] d_mem_data_out,
    input  logic        d_mem_be0,
    input  logic        d_mem_be1,
    output logic        d_mem_rdy,
    output logic [15:0] d_mem_data_in,
    output logic        wp_fault
);

    localparam int         DEPTH  = 1 << AW;
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_cmd;
    logic [AW-1:0]  r_idx;
    logic [15:0]    r_data;
    logic           r_be0;
    logic           r_be1;
    logic [15:0]    r_mem [DEPTH];

    logic           w_unused_addr;
    logic [AW-1:0]  w_req_idx;
    logic [3:0]     w_load;
    logic           w_go_ack;
    logic           w_acc_cmd;
    logic [AW-1:0]  w_acc_idx;
    logic [15:0]    w_acc_data;
    logic           w_acc_be0;
    logic           w_acc_be1;
    logic [15:0]    w_idx16;
    logic           w_acc_prot;
    logic           w_commit;

    // addr[0] and the bits above the word index only alias; they carry no meaning here
    assign w_unused_addr = ^d_mem_addr;

    // Select the access fields for the ACK-entry edge and decide whether this edge is it
    always_comb begin
        w_req_idx = d_mem_addr[AW:1];
        w_load    = d_mem_cmd ? WR_CNT : RD_CNT;
        if (r_state == S_IDLE) begin
            w_acc_cmd  = d_mem_cmd;
            w_acc_idx  = w_req_idx;
            w_acc_data = d_mem_data_out;
            w_acc_be0  = d_mem_be0;
            w_acc_be1  = d_mem_be1;
            w_go_ack   = d_mem_assert && (w_load == 4'd0);
        end else begin
            w_acc_cmd  = r_cmd;
            w_acc_idx  = r_idx;
            w_acc_data = r_data;
            w_acc_be0  = r_be0;
            w_acc_be1  = r_be1;
            w_go_ack   = (r_state == S_WAIT) && (r_cnt == 4'd1);
        end
        w_idx16    = 16'(w_acc_idx);
        w_acc_prot = (WP_LO <= WP_HI) && (w_idx16 >= WP_LO) && (w_idx16 <= WP_HI);
        // Reset on this edge aborts the access, so the write must not land
        w_commit   = a_rst && w_go_ack && w_acc_cmd && !w_acc_prot;
    end

    // Byte-lane writes into the array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_commit && w_acc_be0) r_mem[w_acc_idx][7:0]  <= w_acc_data[7:0];
        if (w_commit && w_acc_be1) r_mem[w_acc_idx][15:8] <= w_acc_data[15:8];
    end

    // Request FSM, wait counter, registered handshake outputs and read data
    always_ff @(posedge clk) begin
        if (!a_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_cmd         <= 1'b0;
            r_idx         <= '0;
            r_data        <= 16'h0000;
            r_be0         <= 1'b0;
            r_be1         <= 1'b0;
            d_mem_rdy     <= 1'b0;
            wp_fault      <= 1'b0;
            d_mem_data_in <= 16'h0000;
        end else begin
            d_mem_rdy <= w_go_ack;
            wp_fault  <= w_go_ack && w_acc_cmd && w_acc_prot;
            if (w_go_ack && !w_acc_cmd) d_mem_data_in <= r_mem[w_acc_idx];
            case (r_state)
                S_IDLE: begin
                    if (d_mem_assert) begin
                        r_cmd   <= d_mem_cmd;
                        r_idx   <= w_req_idx;
                        r_data  <= d_mem_data_out;
                        r_be0   <= d_mem_be0;
                        r_be1   <= d_mem_be1;
                        r_cnt   <= w_load;
                        r_state <= (w_load == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_ACK;
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
